// File: rtl/cfg_reg_bank_if.sv
// Bus interface for cfg_reg_bank: write/read request signals driven by the
// host (master) and the register bank's outputs (slave).
//   wr_in/wr_addr_in/data_in : level-sensitive write request, one per cycle
//   rd_in/rd_addr_in         : read request, data returned one cycle later
//   cfg_active_out           : committed register values, register i at [i*DATA_W +: DATA_W]
//   cmd_pulse_out            : one-cycle command pulse value
//   rd_data_out/rd_valid_out : registered read data and its strobe
//   dirty_out/addr_err_out   : uncommitted-writes flag, sticky bad-address flag
//   wr_cnt_out               : saturating accepted-write count
interface cfg_reg_bank_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_REGS = 20
);
  logic                         wr_in;
  logic [ADDR_W-1:0]            wr_addr_in;
  logic [DATA_W-1:0]            data_in;
  logic                         rd_in;
  logic [ADDR_W-1:0]            rd_addr_in;
  logic [NUM_REGS*DATA_W-1:0]   cfg_active_out;
  logic [DATA_W-1:0]            cmd_pulse_out;
  logic [DATA_W-1:0]            rd_data_out;
  logic                         rd_valid_out;
  logic                         dirty_out;
  logic                         addr_err_out;
  logic [15:0]                  wr_cnt_out;

  modport master (
    output wr_in, wr_addr_in, data_in, rd_in, rd_addr_in,
    input  cfg_active_out, cmd_pulse_out, rd_data_out, rd_valid_out,
           dirty_out, addr_err_out, wr_cnt_out
  );

  modport slave (
    input  wr_in, wr_addr_in, data_in, rd_in, rd_addr_in,
    output cfg_active_out, cmd_pulse_out, rd_data_out, rd_valid_out,
           dirty_out, addr_err_out, wr_cnt_out
  );
endinterface

// File: rtl/cfg_reg_bank.sv
// Configuration register bank with shadow/active copies.
// Writes land in the shadow copy; a commit write to CTRL_ADDR (bit 0) copies
// all shadow registers to the active copy in one edge. Writes to CMD_ADDR
// produce a one-cycle pulse on cmd_pulse_out. CTRL_ADDR reads return
// {addr_err, 14'b0, dirty}; CTRL_ADDR write bit 15 clears addr_err.
// Ports:
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : cfg_reg_bank_if slave modport (requests in, status/data out)
module cfg_reg_bank #(
  parameter int unsigned                  DATA_W      = 16,
  parameter int unsigned                  ADDR_W      = 8,
  parameter int unsigned                  NUM_REGS    = 20,
  parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL     = '0,
  parameter logic [ADDR_W-1:0]            CMD_ADDR    = ADDR_W'(8'hF0),
  parameter logic [ADDR_W-1:0]            CTRL_ADDR   = ADDR_W'(8'hF1),
  parameter bit                           AUTO_COMMIT = 1'b0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  cfg_reg_bank_if.slave bus
);

  // Bit 15 of a control write clears addr_err; narrower buses have no such bit.
  localparam int unsigned CLR_BIT = (DATA_W > 15) ? 15 : DATA_W - 1;
  localparam bit          HAS_CLR = (DATA_W > 15);

  typedef logic [DATA_W-1:0] word_t;

  word_t             shadow_q [NUM_REGS];
  word_t             active_q [NUM_REGS];
  word_t             cmd_pulse_q;
  word_t             rd_data_q;
  word_t             rd_data_d;
  logic              rd_valid_q;
  logic              dirty_q;
  logic              addr_err_q;
  logic [15:0]       wr_cnt_q;
  logic [15:0]       wr_cnt_d;
  logic [NUM_REGS-1:0] wr_sel;
  logic              rd_hit;
  logic              wr_reg;
  logic              wr_cmd;
  logic              wr_ctrl;
  logic              wr_bad;
  logic              commit;
  logic              clr_err;
  logic [15:0]       status;

  // Address decode; register space takes priority over the special addresses.
  always_comb begin
    wr_sel    = '0;
    rd_hit    = 1'b0;
    rd_data_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = bus.wr_in && (bus.wr_addr_in == ADDR_W'(i));
      if (bus.rd_addr_in == ADDR_W'(i)) begin
        rd_hit    = 1'b1;
        rd_data_d = shadow_q[i];
      end
    end
    wr_reg  = |wr_sel;
    wr_cmd  = bus.wr_in && !wr_reg && (bus.wr_addr_in == CMD_ADDR);
    wr_ctrl = bus.wr_in && !wr_reg && !wr_cmd && (bus.wr_addr_in == CTRL_ADDR);
    wr_bad  = bus.wr_in && !wr_reg && !wr_cmd && !wr_ctrl;
    commit  = wr_ctrl && bus.data_in[0];
    clr_err = wr_ctrl && HAS_CLR && bus.data_in[CLR_BIT];
    status  = {addr_err_q, 14'b0, dirty_q};
    if (!rd_hit && (bus.rd_addr_in == CTRL_ADDR)) begin
      rd_data_d = DATA_W'(status);
    end
    wr_cnt_d = wr_cnt_q;
    if ((wr_reg || wr_cmd || wr_ctrl) && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
        active_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end
      cmd_pulse_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      dirty_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          shadow_q[i] <= bus.data_in;
        end
        // Commit copies the pre-edge shadow; a commit cycle never carries a
        // register write, so nothing is lost.
        if (AUTO_COMMIT) begin
          if (wr_sel[i]) begin
            active_q[i] <= bus.data_in;
          end
        end else if (commit) begin
          active_q[i] <= shadow_q[i];
        end
      end
      cmd_pulse_q <= wr_cmd ? bus.data_in : '0;
      rd_valid_q  <= bus.rd_in;
      if (bus.rd_in) begin
        rd_data_q <= rd_data_d;
      end
      if (commit) begin
        dirty_q <= 1'b0;
      end else if (wr_reg && !AUTO_COMMIT) begin
        dirty_q <= 1'b1;
      end
      if (wr_bad) begin
        addr_err_q <= 1'b1;
      end else if (clr_err) begin
        addr_err_q <= 1'b0;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    bus.cfg_active_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      bus.cfg_active_out[i*DATA_W +: DATA_W] = active_q[i];
    end
  end

  assign bus.cmd_pulse_out = cmd_pulse_q;
  assign bus.rd_data_out   = rd_data_q;
  assign bus.rd_valid_out  = rd_valid_q;
  assign bus.dirty_out     = dirty_q;
  assign bus.addr_err_out  = addr_err_q;
  assign bus.wr_cnt_out    = wr_cnt_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Self-checking bench for cfg_reg_bank: a table of write/read vectors with
// hand-derived counter/flag expectations, a reference model feeding a read
// scoreboard, and hand-written sequences for pulses, same-cycle read/write,
// saturation and asynchronous reset. A second instance runs AUTO_COMMIT=1
// on the same stimulus.
module tb_cfg_reg_bank;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NR = 20;
  localparam int W  = NR * DW;

  function automatic logic [W-1:0] mk_rst();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = 16'hA000 + 16'(i);
    return r;
  endfunction
  localparam logic [W-1:0] RSTV = mk_rst();

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfg_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) b0 ();
  cfg_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) b1 ();

  cfg_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RST_VAL(RSTV),
                 .CMD_ADDR(8'hF0), .CTRL_ADDR(8'hF1), .AUTO_COMMIT(1'b0))
    dut0 (.clk_in(clk), .rst_in(rst), .bus(b0.slave));
  cfg_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RST_VAL(RSTV),
                 .CMD_ADDR(8'hF0), .CTRL_ADDR(8'hF1), .AUTO_COMMIT(1'b1))
    dut1 (.clk_in(clk), .rst_in(rst), .bus(b1.slave));

  assign b1.wr_in      = b0.wr_in;
  assign b1.wr_addr_in = b0.wr_addr_in;
  assign b1.data_in    = b0.data_in;
  assign b1.rd_in      = b0.rd_in;
  assign b1.rd_addr_in = b0.rd_addr_in;

  int checks = 0;
  int fails  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkW(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model (AUTO_COMMIT=0 behaviour; AUTO_COMMIT=1 active == m_sh)
  logic [15:0] m_sh  [NR];
  logic [15:0] m_act [NR];
  logic        m_dirty, m_err, m_rdv;
  logic [15:0] m_cnt, m_pulse;
  logic [15:0] rd_q [$];
  bit          mon_en = 1'b0;

  function automatic logic [W-1:0] pack_sh();
    logic [W-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_sh[i];
    return r;
  endfunction

  function automatic logic [W-1:0] pack_act();
    logic [W-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_act[i];
    return r;
  endfunction

  task automatic model_reset();
    logic [W-1:0] rv;
    rv = RSTV;
    for (int i = 0; i < NR; i++) begin
      m_sh[i]  = rv[i*DW +: DW];
      m_act[i] = rv[i*DW +: DW];
    end
    m_dirty = 1'b0; m_err = 1'b0; m_rdv = 1'b0;
    m_cnt = '0; m_pulse = '0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [7:0] addr);
    for (int i = 0; i < NR; i++) if (addr == 8'(i)) return m_sh[i];
    if (addr == 8'hF1) return {m_err, 14'b0, m_dirty};
    return 16'h0000;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Drive one cycle of stimulus; model advances at the same edge as the DUT.
  task automatic step(input logic wr, input logic [7:0] addr, input logic [15:0] data,
                      input logic rd, input logic [7:0] raddr);
    logic hit;
    b0.wr_in = wr; b0.wr_addr_in = addr; b0.data_in = data;
    b0.rd_in = rd; b0.rd_addr_in = raddr;
    if (rd) rd_q.push_back(exp_rd(raddr));
    @(posedge clk);
    m_rdv = rd;
    m_pulse = '0;
    if (wr) begin
      hit = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (addr == 8'(i)) begin
          m_sh[i] = data;
          hit = 1'b1;
        end
      end
      if (hit) begin
        m_dirty = 1'b1;
        m_cnt = sat_inc(m_cnt);
      end else if (addr == 8'hF0) begin
        m_pulse = data;
        m_cnt = sat_inc(m_cnt);
      end else if (addr == 8'hF1) begin
        if (data[0]) begin
          for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
          m_dirty = 1'b0;
        end
        if (data[15]) m_err = 1'b0;
        m_cnt = sat_inc(m_cnt);
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  // Continuous monitor on the falling edge
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk1("rd_valid", b0.rd_valid_out, m_rdv);
      if (b0.rd_valid_out) begin
        if (rd_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL rd_data: got %h with no expected entry", b0.rd_data_out);
        end else begin
          chk16("rd_data", b0.rd_data_out, rd_q.pop_front());
        end
      end
      chk16("cmd_pulse", b0.cmd_pulse_out, m_pulse);
      chk1("dirty", b0.dirty_out, m_dirty);
      chk1("addr_err", b0.addr_err_out, m_err);
      chk16("wr_cnt", b0.wr_cnt_out, m_cnt);
      chkW("active", b0.cfg_active_out, pack_act());
      chkW("auto_active", b1.cfg_active_out, pack_sh());
      chk1("auto_dirty", b1.dirty_out, 1'b0);
    end
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        rd;
    logic [7:0]  raddr;
    logic [15:0] cnt;
    logic        dirty;
    logic        err;
  } vec_t;

  vec_t tbl [$];
  logic [W-1:0] all5;

  initial begin
    for (int i = 0; i < NR; i++)
      tbl.push_back('{1'b1, 8'(i), 16'h0005, 1'b0, 8'h00, 16'(i + 1), 1'b1, 1'b0});
    for (int i = 0; i < NR; i++)
      tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b1, 8'(i), 16'd20, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 8'hF1, 16'h0001, 1'b0, 8'h00, 16'd21, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b1, 8'hF1, 16'd21, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'hF0, 16'h0003, 1'b0, 8'h00, 16'd22, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'd22, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'hF0, 16'h0007, 1'b0, 8'h00, 16'd23, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'hF0, 16'h0009, 1'b0, 8'h00, 16'd24, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'd24, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h20, 16'hBAD1, 1'b0, 8'h00, 16'd24, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 16'h0000, 1'b1, 8'hF1, 16'd24, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'hF1, 16'h8000, 1'b0, 8'h00, 16'd25, 1'b0, 1'b0});

    for (int i = 0; i < NR; i++) all5[i*DW +: DW] = 16'h0005;

    b0.wr_in = 1'b0; b0.wr_addr_in = '0; b0.data_in = '0;
    b0.rd_in = 1'b0; b0.rd_addr_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk16("rst_wr_cnt", b0.wr_cnt_out, 16'h0000);
    chk1("rst_dirty", b0.dirty_out, 1'b0);
    chk1("rst_addr_err", b0.addr_err_out, 1'b0);
    chk16("rst_cmd_pulse", b0.cmd_pulse_out, 16'h0000);
    chk1("rst_rd_valid", b0.rd_valid_out, 1'b0);
    chk16("rst_rd_data", b0.rd_data_out, 16'h0000);
    chkW("rst_active", b0.cfg_active_out, RSTV);
    chkW("rst_auto_active", b1.cfg_active_out, RSTV);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].rd, tbl[k].raddr);
      chk16("tbl_wr_cnt", b0.wr_cnt_out, tbl[k].cnt);
      chk1("tbl_dirty", b0.dirty_out, tbl[k].dirty);
      chk1("tbl_addr_err", b0.addr_err_out, tbl[k].err);
      if (k == NR - 1) chkW("active_before_commit", b0.cfg_active_out, RSTV);
      if (k == 2 * NR) chkW("active_after_commit", b0.cfg_active_out, all5);
    end

    // Command pulses: single, then back-to-back
    step(1'b1, 8'hF0, 16'h0003, 1'b0, 8'h00);
    chk16("pulse_single", b0.cmd_pulse_out, 16'h0003);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk16("pulse_single_end", b0.cmd_pulse_out, 16'h0000);
    step(1'b1, 8'hF0, 16'h000A, 1'b0, 8'h00);
    chk16("pulse_b2b_first", b0.cmd_pulse_out, 16'h000A);
    step(1'b1, 8'hF0, 16'h000B, 1'b0, 8'h00);
    chk16("pulse_b2b_second", b0.cmd_pulse_out, 16'h000B);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk16("pulse_b2b_end", b0.cmd_pulse_out, 16'h0000);

    // Same-cycle read and write of one register returns the old value
    step(1'b1, 8'd3, 16'h1234, 1'b1, 8'd3);
    chk16("rw_same_cycle", b0.rd_data_out, 16'h0005);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'd3);
    chk16("rw_after", b0.rd_data_out, 16'h1234);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);

    // Write counter saturation
    while (m_cnt != 16'hFFFF) step(1'b1, 8'd0, m_cnt, 1'b0, 8'h00);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk16("cnt_saturated", b0.wr_cnt_out, 16'hFFFF);
    step(1'b1, 8'hF0, 16'h0001, 1'b0, 8'h00);
    chk16("cnt_stays_saturated", b0.wr_cnt_out, 16'hFFFF);
    step(1'b1, 8'h40, 16'h0000, 1'b0, 8'h00);
    chk1("err_before_reset", b0.addr_err_out, 1'b1);

    // Asynchronous reset in the middle of held command writes and reads
    mon_en = 1'b0;
    b0.wr_in = 1'b1; b0.wr_addr_in = 8'hF0; b0.data_in = 16'h0055;
    b0.rd_in = 1'b1; b0.rd_addr_in = 8'd1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk16("async_rst_pulse", b0.cmd_pulse_out, 16'h0000);
    chk1("async_rst_rd_valid", b0.rd_valid_out, 1'b0);
    chk16("async_rst_rd_data", b0.rd_data_out, 16'h0000);
    chk1("async_rst_dirty", b0.dirty_out, 1'b0);
    chk1("async_rst_err", b0.addr_err_out, 1'b0);
    chk16("async_rst_cnt", b0.wr_cnt_out, 16'h0000);
    chkW("async_rst_active", b0.cfg_active_out, RSTV);
    chkW("async_rst_auto_active", b1.cfg_active_out, RSTV);
    @(posedge clk);
    #1;
    chk16("rst_hold_cnt", b0.wr_cnt_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    rd_q.delete();
    model_reset();
    mon_en = 1'b1;
    step(1'b1, 8'd4, 16'h0077, 1'b0, 8'h00);
    chk16("first_write_after_rst", b0.wr_cnt_out, 16'h0001);
    chk1("first_write_dirty", b0.dirty_out, 1'b1);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'd4);
    chk16("readback_after_rst", b0.rd_data_out, 16'h0077);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk16("scoreboard_drained", 16'(rd_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
